// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - ARM-subset multicycle control FSM with cond/flag logic
// Optional MCTRL_CMP_EN: cmd 1010 decodes as CMP (SUB, S forced, no register write).
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ResultSrc
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  flags_q, flags_d;
  logic        condex_q, condex_d;

  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  cmd;
  logic        is_str, is_b;
  logic        flag_n, flag_z, flag_c, flag_v;
  logic        cond_ok;
  logic        cmd_ok, cmd_logic, cmd_write, cmd_s;
  logic [1:0]  cmd_alu;
  logic        pcw_raw, mw_raw, irw_raw, rw_raw;
  logic        unused_instr;

  assign cond   = Instr[31:28];
  assign op     = Instr[27:26];
  assign funct  = Instr[25:20];
  assign cmd    = funct[4:1];
  assign is_str = (op == 2'b01) && !funct[0];
  assign is_b   = (op == 2'b10);
  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;
  assign unused_instr = ^Instr[19:0];

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'b0000: cond_ok = flag_z;
      4'b0001: cond_ok = !flag_z;
      4'b0010: cond_ok = flag_c;
      4'b0011: cond_ok = !flag_c;
      4'b0100: cond_ok = flag_n;
      4'b0101: cond_ok = !flag_n;
      4'b0110: cond_ok = flag_v;
      4'b0111: cond_ok = !flag_v;
      4'b1000: cond_ok = flag_c && !flag_z;
      4'b1001: cond_ok = !flag_c || flag_z;
      4'b1010: cond_ok = (flag_n == flag_v);
      4'b1011: cond_ok = (flag_n != flag_v);
      4'b1100: cond_ok = !flag_z && (flag_n == flag_v);
      4'b1101: cond_ok = flag_z || (flag_n != flag_v);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Unsupported commands neither write the register file nor touch the flags.
  always_comb begin
    cmd_ok    = 1'b1;
    cmd_logic = 1'b0;
    cmd_write = 1'b1;
    cmd_s     = funct[0];
    cmd_alu   = 2'b00;
    case (cmd)
      4'b0100: cmd_alu = 2'b00;
      4'b0010: cmd_alu = 2'b01;
      4'b0000: begin
        cmd_alu   = 2'b10;
        cmd_logic = 1'b1;
      end
      4'b1100: begin
        cmd_alu   = 2'b11;
        cmd_logic = 1'b1;
      end
`ifdef MCTRL_CMP_EN
      4'b1010: begin
        cmd_alu   = 2'b01;
        cmd_write = 1'b0;
        cmd_s     = 1'b1;
      end
`endif
      default: begin
        cmd_ok    = 1'b0;
        cmd_write = 1'b0;
        cmd_s     = 1'b0;
      end
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      2'b01:   ImmSrc = 2'b01;
      2'b10:   ImmSrc = 2'b10;
      default: ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    flags_d  = flags_q;
    condex_d = condex_q;
    if (state_q == S_DECODE) begin
      condex_d = cond_ok;
    end
    // Logical ops leave C and V alone.
    if (((state_q == S_EXECR) || (state_q == S_EXECI)) && condex_q && cmd_ok && cmd_s) begin
      flags_d = cmd_logic ? {ALUFlags[3:2], flags_q[1:0]} : ALUFlags;
    end
  end

  always_comb begin
    state_d    = S_FETCH;
    pcw_raw    = 1'b0;
    mw_raw     = 1'b0;
    irw_raw    = 1'b0;
    rw_raw     = 1'b0;
    AdrSrc     = 1'b0;
    RegSrc     = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    ResultSrc  = 2'b00;
    case (state_q)
      S_FETCH: begin
        irw_raw   = 1'b1;
        pcw_raw   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        RegSrc    = is_b ? 2'b01 : (is_str ? 2'b10 : 2'b00);
        case (op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        RegSrc  = is_str ? 2'b10 : 2'b00;
        state_d = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        rw_raw    = condex_q;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc  = 1'b1;
        RegSrc  = is_str ? 2'b10 : 2'b00;
        mw_raw  = condex_q;
        state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUControl = cmd_alu;
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = cmd_alu;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        rw_raw  = condex_q && cmd_write;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        RegSrc    = 2'b01;
        pcw_raw   = condex_q;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are gated by reset so an aborted instruction cannot commit anything.
  assign PCWrite  = pcw_raw && reset;
  assign MemWrite = mw_raw && reset;
  assign IRWrite  = irw_raw && reset;
  assign RegWrite = rw_raw && reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit sequencing the ARM-subset datapath as a multicycle machine: one shared memory port, registered IR/Data/A/WriteData/ALUOut in the datapath, ALU reused for PC increment.
- Decodes Instr, holds the condition flags, evaluates the cond field and drives every datapath strobe/mux select per state.
- Supports DP register/immediate (ADD, SUB, AND, ORR, optional S), LDR/STR with immediate offset, B.

Parameters:
- STATE_W, 4, width of the state register (10 states used)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Instr  in  32  current IR contents (cond[31:28], op[27:26], funct[25:20], Rd[15:12])
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- MemWrite  out  1  data memory write strobe
- IRWrite  out  1  instruction register enable
- RegWrite  out  1  register file write enable
- RegSrc  out  2  [0]=1 selects R15 for RA1; [1]=1 selects Rd for RA2
- ImmSrc  out  2  00=8-bit DP imm, 01=12-bit mem offset, 10=24-bit branch
- ALUSrcA  out  1  0=A register, 1=PC
- ALUSrcB  out  2  00=WriteData reg, 01=ExtImm, 10=constant 4
- ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9; unused codes go to FETCH next cycle.
- Reset (reset=0, async): state=FETCH, Flags=0000, CondExReg=0; while reset low all write strobes (PCWrite, MemWrite, IRWrite, RegWrite) forced 0.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10, PCWrite=1 -> DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (reads PC+8). CondEx computed from Flags and cond, registered into CondExReg. op=01 -> MEMADR; op=00 and funct[5]=0 -> EXECR; op=00 and funct[5]=1 -> EXECI; op=10 -> BRANCH; op=11 -> FETCH (undefined = NOP).
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=00 (U bit ignored). funct[0]=1 -> MEMRD, else -> MEMWR.
- MEMRD: AdrSrc=1 -> MEMWB. MEMWB: ResultSrc=01, RegWrite=CondExReg -> FETCH.
- MEMWR: AdrSrc=1, MemWrite=CondExReg -> FETCH.
- EXECR: ALUSrcA=0, ALUSrcB=00. EXECI: ALUSrcA=0, ALUSrcB=01. Both -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=CondExReg & cmd supported -> FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite=CondExReg -> FETCH.
- cmd=funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR; any other cmd: ALUControl=00, no RegWrite, no flag update.
- Flags update on the clock edge leaving EXECR/EXECI when funct[0]=1 and CondExReg=1: all four bits from ALUFlags for ADD/SUB; logical ops update N,Z only, C,V held.
- Rd=15 with DP/LDR writes R15 normally; no special PC handling.
- RegSrc: 01 in BRANCH/DECODE for B, 10 for STR, 00 otherwise. ImmSrc derived from op: 00->00, 01->01, 10->10.
- cond: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL implemented; 1111 evaluates false.
- Latency: B 3, DP 4, STR 4, LDR 5 cycles; undefined 2.
- Reset asserted mid-instruction: aborts immediately, no pending write completes.

Optional Feature:
- MCTRL_CMP_EN: defined -> cmd 1010 (CMP) decodes as SUB with S forced, flags updated, RegWrite suppressed in ALUWB. Undefined -> cmd 1010 is unsupported (no write, no flags).

Test Plan:
- Reset low mid-MEMADR then release -> next cycle FETCH, IRWrite=1, PCWrite=1, Flags=0000.
- Instr=E0821003 (ADD R1,R2,R3) -> FETCH,DECODE,EXECR,ALUWB; RegWrite=1 only in ALUWB, ALUControl=00.
- Instr=E5921004 (LDR) -> 5 cycles, AdrSrc=1 in MEMRD, ResultSrc=01 and RegWrite=1 in MEMWB; Instr=E5821004 (STR) -> MemWrite=1 in MEMWR only, RegSrc=10.
- Instr=E0500000 (SUBS) with ALUFlags=0100 -> Flags=0100; then 00821003 (ADDEQ) writes, 10821003 (ADDNE) RegWrite=0 throughout.
- Instr=0A000002 (BEQ) with Z=0 -> BRANCH state, PCWrite=0; Z=1 -> PCWrite=1, ResultSrc=10.
- Instr=E1500001 (CMP): with MCTRL_CMP_EN -> flags updated, RegWrite=0; without -> flags unchanged, RegWrite=0.
